// File: rtl/segdisp_avalon.sv
// segdisp_avalon: Avalon-MM slave driving NUM_DIGITS active-low seven-segment digits
//   with per-digit hex/raw mode, enable and hardware blink from an internal prescaler.
// Latency: reads return one cycle after the strobe; hex_out is registered, so a register
//   write or blink phase toggle reaches the pins one cycle later.
// Backpressure: none; every access completes with no wait states.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   avs_chipselect/address/read/write/writedata/readdata   Avalon-MM slave, read latency 1
//   hex_out             7 bits per digit, digit k at [7k+6:7k], bit 0 = segment a, active low
// Optional: define SEGDISP_LZB_EN to add leading-zero blanking (CTRL[24] lzb).
module segdisp_avalon #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int ADDR_W     = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    avs_chipselect,
  input  logic [ADDR_W-1:0]       avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int ND = NUM_DIGITS;
  localparam int PW = $clog2(BLINK_DIV);

  localparam logic [ADDR_W-1:0] A_VALUE  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_RAW_LO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RAW_HI = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);

  logic [4*ND-1:0] r_value;
  logic [ND-1:0]   r_en;
  logic [ND-1:0]   r_blink;
  logic [ND-1:0]   r_raw_sel;
  logic [7*ND-1:0] r_raw;
`ifdef SEGDISP_LZB_EN
  logic            r_lzb;
`endif
  logic [PW-1:0]   r_presc;
  logic            r_phase;
  logic [31:0]     r_readdata;
  logic [7*ND-1:0] r_hex;

  logic            w_wr;
  logic            w_rd;
  logic [31:0]     w_ctrl;
  logic [31:0]     w_raw_lo;
  logic [31:0]     w_raw_hi;
  logic [31:0]     w_presc32;
  logic [31:0]     w_rd_mux;
  logic [ND-1:0]   w_lzb_blank;
  logic [7*ND-1:0] w_hex;
  logic            w_unused;

  assign w_wr = avs_chipselect & avs_write;
  assign w_rd = avs_chipselect & avs_read;

  // Standard active-low hex decode, segment a in bit 0.
  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0: f_hex7 = 7'h40;
      4'h1: f_hex7 = 7'h79;
      4'h2: f_hex7 = 7'h24;
      4'h3: f_hex7 = 7'h30;
      4'h4: f_hex7 = 7'h19;
      4'h5: f_hex7 = 7'h12;
      4'h6: f_hex7 = 7'h02;
      4'h7: f_hex7 = 7'h78;
      4'h8: f_hex7 = 7'h00;
      4'h9: f_hex7 = 7'h10;
      4'hA: f_hex7 = 7'h08;
      4'hB: f_hex7 = 7'h03;
      4'hC: f_hex7 = 7'h46;
      4'hD: f_hex7 = 7'h21;
      4'hE: f_hex7 = 7'h06;
      default: f_hex7 = 7'h0E;
    endcase
  endfunction

  // Register file writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value   <= '0;
      r_en      <= '1;
      r_blink   <= '0;
      r_raw_sel <= '0;
      r_raw     <= '0;
`ifdef SEGDISP_LZB_EN
      r_lzb     <= 1'b0;
`endif
    end else if (w_wr) begin
      case (avs_address)
        A_VALUE: r_value <= avs_writedata[4*ND-1:0];
        A_CTRL: begin
          r_en      <= avs_writedata[0+:ND];
          r_blink   <= avs_writedata[8+:ND];
          r_raw_sel <= avs_writedata[16+:ND];
`ifdef SEGDISP_LZB_EN
          r_lzb     <= avs_writedata[24];
`endif
        end
        A_RAW_LO, A_RAW_HI: begin
          // Digits 0..3 live in RAW_LO, 4..7 in RAW_HI; same byte lane k%4 in both.
          for (int k = 0; k < ND; k++) begin
            if ((k < 4) == (avs_address == A_RAW_LO))
              r_raw[7*k+:7] <= avs_writedata[8*(k%4)+:7];
          end
        end
        default: ;
      endcase
    end
  end

  // Blink prescaler: phase toggles each time the count wraps, giving a 2*BLINK_DIV period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_phase <= 1'b0;
    end else if (r_presc == PW'(BLINK_DIV - 1)) begin
      r_presc <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Read-back views; bits of unimplemented digits stay 0.
  always_comb begin
    w_ctrl   = '0;
    w_raw_lo = '0;
    w_raw_hi = '0;
    w_ctrl[0+:ND]  = r_en;
    w_ctrl[8+:ND]  = r_blink;
    w_ctrl[16+:ND] = r_raw_sel;
`ifdef SEGDISP_LZB_EN
    w_ctrl[24]     = r_lzb;
`endif
    for (int k = 0; k < ND; k++) begin
      if (k < 4) w_raw_lo[8*(k%4)+:7] = r_raw[7*k+:7];
      else       w_raw_hi[8*(k%4)+:7] = r_raw[7*k+:7];
    end
  end

  assign w_presc32 = 32'(r_presc);

  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      A_VALUE:  w_rd_mux = 32'(r_value);
      A_CTRL:   w_rd_mux = w_ctrl;
      A_RAW_LO: w_rd_mux = w_raw_lo;
      A_RAW_HI: w_rd_mux = w_raw_hi;
      A_STATUS: w_rd_mux = {w_presc32[23:0], 7'd0, r_phase};
      default:  w_rd_mux = '0;
    endcase
  end

  // Sampled from pre-write state, so a same-cycle read/write returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rd_mux;
  end

`ifdef SEGDISP_LZB_EN
  // Walk down from the top digit blanking hex-mode zeros until a nonzero or raw digit.
  always_comb begin
    logic w_run;
    w_lzb_blank = '0;
    w_run       = r_lzb;
    for (int k = ND - 1; k >= 1; k--) begin
      if (w_run && !r_raw_sel[k] && (r_value[4*k+:4] == 4'd0)) w_lzb_blank[k] = 1'b1;
      else w_run = 1'b0;
    end
  end
`else
  assign w_lzb_blank = '0;
`endif

  always_comb begin
    w_hex = '1;
    for (int k = 0; k < ND; k++) begin
      if (!r_en[k] || (r_blink[k] && r_phase) || w_lzb_blank[k])
        w_hex[7*k+:7] = 7'h7F;
      else if (r_raw_sel[k])
        w_hex[7*k+:7] = ~r_raw[7*k+:7];
      else
        w_hex[7*k+:7] = f_hex7(r_value[4*k+:4]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_hex <= '1;
    else          r_hex <= w_hex;
  end

  assign avs_readdata = r_readdata;
  assign hex_out      = r_hex;

  // Write-data bits outside the register fields and high prescaler bits are intentionally dropped.
  assign w_unused = ^{avs_writedata, w_presc32[31:24]};

endmodule

// File: tb/tb_segdisp_avalon.sv
`timescale 1ns/1ps
module tb_segdisp_avalon;

  localparam int ND = 4;
  localparam int BD = 4;
  localparam int AW = 3;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            avs_chipselect = 1'b0;
  logic [AW-1:0]   avs_address = '0;
  logic            avs_read = 1'b0;
  logic            avs_write = 1'b0;
  logic [31:0]     avs_writedata = '0;
  logic [31:0]     avs_readdata;
  logic [7*ND-1:0] hex_out;

  always #5 clk = ~clk;

  segdisp_avalon #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .avs_chipselect(avs_chipselect), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .hex_out(hex_out)
  );

  // Reference model state: one entry per digit, plus elapsed cycles since reset release.
  int         m_val [ND];
  bit         m_en [ND];
  bit         m_blink [ND];
  bit         m_rawsel [ND];
  logic [6:0] m_raw [ND];
  bit         m_lzb;
  int         m_k;

  logic [7*ND-1:0] q_hex [$];
  logic [31:0]     q_rd [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void mdl_reset();
    for (int k = 0; k < ND; k++) begin
      m_val[k] = 0; m_en[k] = 1'b1; m_blink[k] = 1'b0; m_rawsel[k] = 1'b0; m_raw[k] = '0;
    end
    m_lzb = 1'b0;
    m_k = 0;
  endfunction

  function automatic logic [7*ND-1:0] mdl_hex(input bit ph);
    logic [7*ND-1:0] h;
    int lead;
    bit blank;
    lead = 0;
    for (int k = 0; k < ND; k++) if (m_rawsel[k] || m_val[k] != 0) lead = k;
    for (int k = 0; k < ND; k++) begin
      blank = !m_en[k] || (m_blink[k] && ph) || (m_lzb && k > lead);
      if (blank)            h[7*k+:7] = 7'h7F;
      else if (m_rawsel[k]) h[7*k+:7] = ~m_raw[k];
      else                  h[7*k+:7] = SEG[m_val[k]];
    end
    return h;
  endfunction

  function automatic logic [31:0] mdl_rd(input int a);
    logic [31:0] r;
    r = '0;
    case (a)
      0: for (int k = 0; k < ND; k++) r |= 32'(m_val[k]) << (4 * k);
      1: begin
        for (int k = 0; k < ND; k++)
          r |= (32'(m_en[k]) << k) | (32'(m_blink[k]) << (8 + k)) | (32'(m_rawsel[k]) << (16 + k));
        r |= 32'(m_lzb) << 24;
      end
      2: for (int k = 0; k < ND && k < 4; k++) r |= 32'(m_raw[k]) << (8 * k);
      3: for (int k = 4; k < ND; k++) r |= 32'(m_raw[k]) << (8 * (k - 4));
      4: r = (32'(m_k % BD) << 8) | 32'((m_k / BD) % 2);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void mdl_write(input int a, input logic [31:0] d);
    case (a)
      0: for (int k = 0; k < ND; k++) m_val[k] = int'(d[4*k+:4]);
      1: begin
        for (int k = 0; k < ND; k++) begin
          m_en[k] = d[k]; m_blink[k] = d[8+k]; m_rawsel[k] = d[16+k];
        end
`ifdef SEGDISP_LZB_EN
        m_lzb = d[24];
`endif
      end
      2: for (int k = 0; k < ND && k < 4; k++) m_raw[k] = d[8*k+:7];
      3: for (int k = 4; k < ND; k++) m_raw[k] = d[8*(k-4)+:7];
      default: ;
    endcase
  endfunction

  // Stimulus side of the scoreboard: predict what each edge should produce.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_reset();
      q_hex.delete();
      q_hex.push_back('1);
      q_rd.delete();
    end else begin
      q_hex.push_back(mdl_hex(((m_k / BD) % 2) == 1));
      if (avs_chipselect && avs_read) q_rd.push_back(mdl_rd(int'(avs_address)));
      if (avs_chipselect && avs_write) mdl_write(int'(avs_address), avs_writedata);
      m_k++;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Monitor: compares DUT outputs against queued predictions away from the active edge.
  logic [31:0]     last_rd = '0;
  logic [7*ND-1:0] exp_hex;
  always @(negedge clk) begin
    if (q_hex.size() > 0) begin
      exp_hex = q_hex.pop_front();
      chk("hex_out", 32'(hex_out), 32'(exp_hex));
    end
    if (!reset_n) last_rd = '0;
    if (q_rd.size() > 0) last_rd = q_rd.pop_front();
    chk("readdata", avs_readdata, last_rd);
  end

  task automatic op(input bit cs, input bit rd, input bit wr, input int a, input logic [31:0] d);
    avs_chipselect = cs; avs_read = rd; avs_write = wr;
    avs_address = AW'(a); avs_writedata = d;
    @(negedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d); op(1'b1, 1'b0, 1'b1, a, d); endtask
  task automatic bus_rd(input int a); op(1'b1, 1'b1, 1'b0, a, 32'h0); endtask
  task automatic idle(input int n); repeat (n) begin @(negedge clk); #1; end endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int a;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    idle(3);
    bus_rd(1);
    bus_wr(0, 32'h0000A5F3);
    bus_rd(0);
    idle(2);
    bus_wr(1, 32'h0001000F);
    bus_wr(2, 32'h00000049);
    idle(2);
    bus_wr(1, 32'h0000020F);
    repeat (12) bus_rd(4);
    idle(8);
    // Land a reset in the middle of the blank half-period.
    for (int i = 0; i < 16 && (m_k % (2 * BD)) != (BD + 1); i++) idle(1);
    @(posedge clk); #2 reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #1 reset_n = 1'b1;
    bus_rd(4);
    bus_rd(1);
    idle(2);
    bus_wr(0, 32'h00001234);
    op(1'b1, 1'b1, 1'b1, 0, 32'h00005678);
    bus_rd(0);
    bus_wr(6, 32'hFFFFFFFF);
    bus_rd(6);
    bus_rd(5);
    bus_rd(7);
    bus_wr(4, 32'hFFFFFFFF);
    bus_rd(4);
    op(1'b0, 1'b0, 1'b1, 0, 32'h0000DEAD);
    op(1'b0, 1'b1, 1'b0, 1, 32'h0);
    bus_rd(0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      a = $urandom_range(0, 7);
      op((r[2:0] != 3'd0), r[3], r[4], a, $urandom);
      if (r[7:5] == 3'd0) idle(int'($urandom_range(1, 6)));
    end
`ifdef SEGDISP_LZB_EN
    bus_wr(1, 32'h0100000F);
    bus_wr(0, 32'h00000040);
    idle(3);
    bus_wr(0, 32'h00000000);
    idle(3);
    bus_wr(1, 32'h0101000F);
    bus_wr(2, 32'h00000000);
    idle(2);
    bus_rd(1);
`endif
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
